nand_flash_responder: RTL and testbench
=======================================

// Module: nand_flash_responder
// PURPOSE
// Synthesizable NAND flash device model: the responder on the other end of the
// host-side flash controller bus. Decodes CE_N/CLE/ALE/WE_N/RE_N/WP_N, latches
// commands, addresses and data, and drives R/B_N and the read bus. Holds a small
// page array so controller firmware runs on FPGA with no real flash attached.
// PARAMETERS
// PAGE_BYTES  16     bytes per page (power of 2, >=2); column wraps at PAGE_BYTES
// NUM_PAGES   4      pages in array (power of 2); row byte uses low log2 bits
// BUSY_CYCLES 32     clk cycles R/B_N held low per operation; must be >= PAGE_BYTES
// ID0/ID1     8'hEC/8'hDA  bytes returned by READ ID
// IDLEDATA    8'hAA  flash_q value whenever no byte is being driven
// PORTS
// clk             in   1  system clock; all inputs sampled here
// rst             in   1  synchronous reset, active low
// iCE_N           in   1  chip enable, active low
// iCLE, iALE      in   1  command / address latch enable
// iWE_N, iRE_N    in   1  write / read strobes, active low
// iWP_N           in   1  write protect, active low
// flash_data      in   8  bus value driven by controller
// flash_q         out  8  bus value driven by this device (registered)
// q_oe            out  1  1 = device drives bus (registered)
// oRB_N           out  1  ready(1)/busy(0), registered
// BEHAVIOUR
// - Reset (rst=0 at clk edge): state IDLE, oRB_N=1, q_oe=0, flash_q=IDLEDATA,
//   column/row=0, status FAIL=0, out_mode=PAGE. Page array and buffer not reset.
// - Strobe edges: we_d/re_d registered copies. WE rise = we_d==0 && iWE_N==1;
//   RE rise analogous. Edges ignored while iCE_N=1. Byte latched on WE rise is
//   data_d (flash_data registered previous cycle). CLE&ALE both 1: edge ignored.
// - WE rise with CLE=1 -> command; ALE=1 -> address byte; neither -> data byte.
// - Commands: 00 read setup (out_mode=PAGE; ADDR1 next); 30 read confirm;
//   80 program setup (ADDR1); 10 program confirm; 70 status; 90 read ID (ADDR_ID);
//   FF reset. Unknown command -> IDLE, no effect.
// - States: IDLE, ADDR1(column), ADDR2(row), ADDR_ID, DATA_IN, BUSY_RD, BUSY_PG,
//   BUSY_RST, DATA_OUT. ADDR1->ADDR2 on address byte; ADDR2->IDLE after read
//   setup (awaits 30) or ->DATA_IN after program setup. Non-address edge in an
//   ADDR state: command re-decoded, data ignored.
// - DATA_IN: each data byte -> buffer[column], column+1 mod PAGE_BYTES; 10 ->
//   BUSY_PG. 30 while IDLE after read addr -> BUSY_RD.
// - BUSY_*: oRB_N=0 exactly BUSY_CYCLES cycles starting cycle after the confirm
//   edge. BUSY_RD copies array[row] to buffer one byte/cycle; BUSY_PG copies
//   buffer to array[row]; if iWP_N=0 at confirm, no write and FAIL=1, else FAIL=0.
//   End of busy -> DATA_OUT (read) or IDLE (program/reset), oRB_N=1.
// - During busy only 70 and FF accepted; others ignored. FF mid-busy restarts
//   counter as BUSY_RST; array page under program then undefined.
// - Read output: in DATA_OUT (or after 70/ID) flash_q holds current byte;
//   q_oe = registered(~iCE_N & ~iRE_N). RE rise advances column (wrap to 0).
//   out_mode STATUS: byte {~WP_N_n? : iWP_N, RB, 5'b0, FAIL} = {iWP_N,oRB_N,5'b0,FAIL},
//   repeated each RE. out_mode ID: ID0, ID1, then 8'h00 repeated.
//   Command 00 alone (no address) returns out_mode to PAGE, column kept.
// - Not outputting or iCE_N=1: q_oe=0, flash_q=IDLEDATA.
// TESTING
// 1 Reset: rst=0 two cycles -> oRB_N=1, q_oe=0, flash_q=8'hAA.
// 2 Program/read: 80, addr 00,02, data 11..1F,00(16B), 10 -> oRB_N low 32 cycles;
//   then 00, addr 00,02, 30, busy, 16 RE pulses -> 11..1F,00 in order.
// 3 Column wrap: read addr col 0E row 02 -> bytes 1F,00,11 (third wraps to col 0).
// 4 WP: iWP_N=0, program row 01 with 55s, 10 -> 70, RE -> 8'h41 (WP,RDY,FAIL);
//   read row 01 unchanged.
// 5 Status in busy: 70 during BUSY_RD -> RE yields 8'h80; after busy 8'hC0; 00 ->
//   page data resumes at held column.
// 6 ID + reset: 90, addr 00, 3 RE -> EC,DA,00; FF during BUSY_PG -> busy 32 cycles,
//   then IDLE, q_oe=0, status FAIL=0.

Source files
------------

// File: rtl/nand_flash_responder.sv
// NAND flash device model: decodes the controller strobes, holds a small page array, drives R/B_N and the read bus.
// Outputs are registered one cycle behind the sampled strobes; no backpressure, the controller paces via R/B_N.
module nand_flash_responder #(
    parameter int          PAGE_BYTES  = 16,
    parameter int          NUM_PAGES   = 4,
    parameter int          BUSY_CYCLES = 32,
    parameter logic [7:0]  ID0         = 8'hEC,
    parameter logic [7:0]  ID1         = 8'hDA,
    parameter logic [7:0]  IDLEDATA    = 8'hAA
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iCE_N,
    input  logic       iCLE,
    input  logic       iALE,
    input  logic       iWE_N,
    input  logic       iRE_N,
    input  logic       iWP_N,
    input  logic [7:0] flash_data,
    output logic [7:0] flash_q,
    output logic       q_oe,
    output logic       oRB_N
);

    localparam int CW   = $clog2(PAGE_BYTES);
    localparam int RW   = $clog2(NUM_PAGES);
    localparam int CNTW = $clog2(BUSY_CYCLES + 1);

    localparam logic [7:0] CMD_READ    = 8'h00;
    localparam logic [7:0] CMD_READ_GO = 8'h30;
    localparam logic [7:0] CMD_PROG    = 8'h80;
    localparam logic [7:0] CMD_PROG_GO = 8'h10;
    localparam logic [7:0] CMD_STATUS  = 8'h70;
    localparam logic [7:0] CMD_ID      = 8'h90;
    localparam logic [7:0] CMD_RESET   = 8'hFF;

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR1, S_ADDR2, S_ADDR_ID, S_DATA_IN,
        S_BUSY_RD, S_BUSY_PG, S_BUSY_RST, S_DATA_OUT
    } state_t;

    typedef enum logic [1:0] {OM_PAGE, OM_STATUS, OM_ID} omode_t;

    state_t          state_q, state_d;
    logic            we_q, re_q;
    logic [7:0]      data_q;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            fail_q, fail_d;
    logic            wp_blk_q, wp_blk_d;
    logic            prog_q, prog_d;
    logic            rd_armed_q, rd_armed_d;
    logic            out_en_q, out_en_d;
    omode_t          omode_q, omode_d;
    logic [1:0]      id_idx_q, id_idx_d;
    logic [7:0]      flash_q_q, flash_q_d;
    logic            q_oe_q, q_oe_d;
    logic            orb_q, orb_d;

    logic [7:0]      buf_q [PAGE_BYTES];
    logic [7:0]      mem_q [NUM_PAGES*PAGE_BYTES];

    logic            we_rise, re_rise;
    logic            cmd_vld, addr_vld, din_vld, cmd_ok;
    logic            busy, busy_done, busy_next;
    logic            start_rd, start_pg;
    logic            copy_act;
    logic [CW-1:0]   copy_col;
    logic [7:0]      out_byte;
    logic            out_act;

    // Strobe edges use the registered copy against the live pin; the latched byte is the one held while WE was low.
    assign we_rise  = ~we_q & iWE_N & ~iCE_N & ~(iCLE & iALE);
    assign re_rise  = ~re_q & iRE_N & ~iCE_N;
    assign cmd_vld  = we_rise & iCLE;
    assign addr_vld = we_rise & iALE;
    assign din_vld  = we_rise & ~iCLE & ~iALE;

    assign busy      = (state_q == S_BUSY_RD) || (state_q == S_BUSY_PG) || (state_q == S_BUSY_RST);
    assign busy_done = busy && (cnt_q == CNTW'(BUSY_CYCLES - 1));
    assign busy_next = (state_d == S_BUSY_RD) || (state_d == S_BUSY_PG) || (state_d == S_BUSY_RST);
    assign cmd_ok    = cmd_vld && (!busy || data_q == CMD_STATUS || data_q == CMD_RESET);
    assign start_rd  = cmd_vld && !busy && data_q == CMD_READ_GO && rd_armed_q && state_q == S_IDLE;
    assign start_pg  = cmd_vld && !busy && data_q == CMD_PROG_GO && state_q == S_DATA_IN;
    assign copy_act  = cnt_q < CNTW'(PAGE_BYTES);
    assign copy_col  = cnt_q[CW-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (busy) begin
            if (cmd_vld && data_q == CMD_RESET) begin
                state_d = S_BUSY_RST;
            end else if (busy_done) begin
                state_d = (state_q == S_BUSY_RD) ? S_DATA_OUT : S_IDLE;
            end
        end else if (cmd_vld) begin
            case (data_q)
                CMD_READ,
                CMD_PROG:    state_d = S_ADDR1;
                CMD_READ_GO: state_d = start_rd ? S_BUSY_RD : S_IDLE;
                CMD_PROG_GO: state_d = start_pg ? S_BUSY_PG : S_IDLE;
                CMD_STATUS:  state_d = (state_q == S_DATA_OUT) ? S_DATA_OUT : S_IDLE;
                CMD_ID:      state_d = S_ADDR_ID;
                CMD_RESET:   state_d = S_BUSY_RST;
                default:     state_d = S_IDLE;
            endcase
        end else if (addr_vld) begin
            case (state_q)
                S_ADDR1:   state_d = S_ADDR2;
                S_ADDR2:   state_d = prog_q ? S_DATA_IN : S_IDLE;
                S_ADDR_ID: state_d = S_DATA_OUT;
                default:   state_d = state_q;
            endcase
        end
    end

    always_comb begin
        case (omode_q)
            OM_STATUS: out_byte = {iWP_N, orb_q, 5'b0, fail_q};
            OM_ID: begin
                case (id_idx_q)
                    2'd0:    out_byte = ID0;
                    2'd1:    out_byte = ID1;
                    default: out_byte = 8'h00;
                endcase
            end
            default:   out_byte = buf_q[col_q];
        endcase
        // Status may be polled while busy; page data is only valid once the buffer load has finished.
        out_act   = out_en_q && !iCE_N && (omode_q == OM_STATUS || !busy);
        flash_q_d = out_act ? out_byte : IDLEDATA;
        q_oe_d    = out_act && !iRE_N;
        orb_d     = !busy_next;
    end

    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        cnt_d      = cnt_q;
        fail_d     = fail_q;
        wp_blk_d   = wp_blk_q;
        prog_d     = prog_q;
        rd_armed_d = rd_armed_q;
        out_en_d   = out_en_q;
        omode_d    = omode_q;
        id_idx_d   = id_idx_q;

        if (busy) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (state_q == S_BUSY_RD && state_d == S_DATA_OUT) begin
            out_en_d = 1'b1;
        end

        if (re_rise && out_en_q && !busy) begin
            if (omode_q == OM_PAGE) begin
                col_d = col_q + 1'b1;
            end else if (omode_q == OM_ID && id_idx_q != 2'd2) begin
                id_idx_d = id_idx_q + 2'd1;
            end
        end

        if (cmd_ok) begin
            rd_armed_d = 1'b0;
            case (data_q)
                CMD_READ: begin
                    omode_d = OM_PAGE;
                    prog_d  = 1'b0;
                end
                CMD_PROG: begin
                    prog_d   = 1'b1;
                    out_en_d = 1'b0;
                end
                CMD_READ_GO: begin
                    // Status reflects the most recent operation, so a read clears a stale program failure.
                    if (start_rd) begin
                        cnt_d    = '0;
                        fail_d   = 1'b0;
                        out_en_d = 1'b0;
                        omode_d  = OM_PAGE;
                    end
                end
                CMD_PROG_GO: begin
                    if (start_pg) begin
                        cnt_d    = '0;
                        fail_d   = ~iWP_N;
                        wp_blk_d = ~iWP_N;
                        out_en_d = 1'b0;
                    end
                end
                CMD_STATUS: begin
                    omode_d    = OM_STATUS;
                    out_en_d   = 1'b1;
                    rd_armed_d = rd_armed_q;
                end
                CMD_ID: begin
                    prog_d   = 1'b0;
                    out_en_d = 1'b0;
                end
                CMD_RESET: begin
                    cnt_d    = '0;
                    fail_d   = 1'b0;
                    wp_blk_d = 1'b0;
                    prog_d   = 1'b0;
                    out_en_d = 1'b0;
                    omode_d  = OM_PAGE;
                    col_d    = '0;
                    row_d    = '0;
                end
                default: ;
            endcase
        end

        if (addr_vld) begin
            case (state_q)
                S_ADDR1: col_d = data_q[CW-1:0];
                S_ADDR2: begin
                    row_d      = data_q[RW-1:0];
                    rd_armed_d = ~prog_q;
                end
                S_ADDR_ID: begin
                    omode_d  = OM_ID;
                    id_idx_d = 2'd0;
                    out_en_d = 1'b1;
                end
                default: ;
            endcase
        end

        if (din_vld && state_q == S_DATA_IN) begin
            col_d = col_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            we_q       <= 1'b1;
            re_q       <= 1'b1;
            data_q     <= 8'h00;
            col_q      <= '0;
            row_q      <= '0;
            cnt_q      <= '0;
            fail_q     <= 1'b0;
            wp_blk_q   <= 1'b0;
            prog_q     <= 1'b0;
            rd_armed_q <= 1'b0;
            out_en_q   <= 1'b0;
            omode_q    <= OM_PAGE;
            id_idx_q   <= 2'd0;
            flash_q_q  <= IDLEDATA;
            q_oe_q     <= 1'b0;
            orb_q      <= 1'b1;
        end else begin
            we_q       <= iWE_N;
            re_q       <= iRE_N;
            data_q     <= flash_data;
            col_q      <= col_d;
            row_q      <= row_d;
            cnt_q      <= cnt_d;
            fail_q     <= fail_d;
            wp_blk_q   <= wp_blk_d;
            prog_q     <= prog_d;
            rd_armed_q <= rd_armed_d;
            out_en_q   <= out_en_d;
            omode_q    <= omode_d;
            id_idx_q   <= id_idx_d;
            flash_q_q  <= flash_q_d;
            q_oe_q     <= q_oe_d;
            orb_q      <= orb_d;
        end
    end

    // Array and page buffer keep their contents across reset, like real cells; copies move one byte per busy cycle.
    always_ff @(posedge clk) begin
        if (din_vld && state_q == S_DATA_IN) begin
            buf_q[col_q] <= data_q;
        end else if (state_q == S_BUSY_RD && copy_act) begin
            buf_q[copy_col] <= mem_q[{row_q, copy_col}];
        end
        if (state_q == S_BUSY_PG && copy_act && !wp_blk_q) begin
            mem_q[{row_q, copy_col}] <= buf_q[copy_col];
        end
    end

    assign flash_q = flash_q_q;
    assign q_oe    = q_oe_q;
    assign oRB_N   = orb_q;

endmodule

// File: tb/tb_nand_flash_responder.sv
// Directed bench for nand_flash_responder: drives controller bus cycles on the falling clock edge and checks bytes and busy timing.
module tb_nand_flash_responder;

    logic       clk = 1'b0;
    logic       rst, iCE_N, iCLE, iALE, iWE_N, iRE_N, iWP_N;
    logic [7:0] flash_data;
    logic [7:0] flash_q;
    logic       q_oe, oRB_N;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    nand_flash_responder dut (
        .clk        (clk),
        .rst        (rst),
        .iCE_N      (iCE_N),
        .iCLE       (iCLE),
        .iALE       (iALE),
        .iWE_N      (iWE_N),
        .iRE_N      (iRE_N),
        .iWP_N      (iWP_N),
        .flash_data (flash_data),
        .flash_q    (flash_q),
        .q_oe       (q_oe),
        .oRB_N      (oRB_N)
    );

    task automatic we_cycle(input logic cle, input logic ale, input logic [7:0] b);
        @(negedge clk);
        iCLE = cle; iALE = ale; flash_data = b; iWE_N = 1'b0;
        @(negedge clk);
        iWE_N = 1'b1;
    endtask

    task automatic cmd(input logic [7:0] b);  we_cycle(1'b1, 1'b0, b); endtask
    task automatic addr(input logic [7:0] b); we_cycle(1'b0, 1'b1, b); endtask
    task automatic din(input logic [7:0] b);  we_cycle(1'b0, 1'b0, b); endtask

    task automatic rd_byte(output logic [7:0] b, output logic oe);
        @(negedge clk);
        iRE_N = 1'b0;
        @(negedge clk);
        b  = flash_q;
        oe = q_oe;
        iRE_N = 1'b1;
    endtask

    // Counts falling edges with R/B_N low, starting right after a confirm cycle; bounded.
    task automatic busy_len(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (oRB_N !== 1'b0) break;
            n++;
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (oRB_N === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; iCE_N = 1'b0; iCLE = 1'b0; iALE = 1'b0;
        iWE_N = 1'b1; iRE_N = 1'b1; iWP_N = 1'b1; flash_data = 8'h00;
        repeat (2) @(negedge clk);
        tests_run++;
        if (oRB_N !== 1'b1) begin tests_failed++; $display("FAIL reset_rb: got %b expected 1", oRB_N); end
        tests_run++;
        if (q_oe !== 1'b0) begin tests_failed++; $display("FAIL reset_oe: got %b expected 0", q_oe); end
        tests_run++;
        if (flash_q !== 8'hAA) begin tests_failed++; $display("FAIL reset_q: got %h expected aa", flash_q); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_program_read;
        logic [7:0] b, exp;
        logic oe;
        int n;
        cmd(8'h80); addr(8'h00); addr(8'h02);
        for (int i = 0; i < 16; i++) din((i == 15) ? 8'h00 : 8'(8'h11 + i));
        cmd(8'h10);
        busy_len(n);
        tests_run++;
        if (n != 32) begin tests_failed++; $display("FAIL prog_busy: got %0d cycles expected 32", n); end
        cmd(8'h00); addr(8'h00); addr(8'h02); cmd(8'h30);
        busy_len(n);
        tests_run++;
        if (n != 32) begin tests_failed++; $display("FAIL read_busy: got %0d cycles expected 32", n); end
        for (int i = 0; i < 16; i++) begin
            exp = (i == 15) ? 8'h00 : 8'(8'h11 + i);
            rd_byte(b, oe);
            tests_run++;
            if (b !== exp) begin tests_failed++; $display("FAIL read_byte%0d: got %h expected %h", i, b, exp); end
            if (i == 0) begin
                tests_run++;
                if (oe !== 1'b1) begin tests_failed++; $display("FAIL read_oe: got %b expected 1", oe); end
            end
        end
    endtask

    task automatic test_column_wrap;
        logic [7:0] b;
        logic [7:0] exp [3];
        logic oe;
        int n;
        exp[0] = 8'h1F; exp[1] = 8'h00; exp[2] = 8'h11;
        cmd(8'h00); addr(8'h0E); addr(8'h02); cmd(8'h30);
        busy_len(n);
        for (int i = 0; i < 3; i++) begin
            rd_byte(b, oe);
            tests_run++;
            if (b !== exp[i]) begin tests_failed++; $display("FAIL wrap_byte%0d: got %h expected %h", i, b, exp[i]); end
        end
    endtask

    task automatic test_write_protect;
        logic [7:0] b;
        logic oe;
        int n;
        cmd(8'h80); addr(8'h00); addr(8'h01);
        din(8'hA0); din(8'hA1); din(8'hA2); din(8'hA3);
        cmd(8'h10);
        busy_len(n);
        iWP_N = 1'b0;
        cmd(8'h80); addr(8'h00); addr(8'h01);
        repeat (4) din(8'h55);
        cmd(8'h10);
        busy_len(n);
        tests_run++;
        if (n != 32) begin tests_failed++; $display("FAIL wp_busy: got %0d cycles expected 32", n); end
        cmd(8'h70);
        rd_byte(b, oe);
        tests_run++;
        if (b !== 8'h41) begin tests_failed++; $display("FAIL wp_status: got %h expected 41", b); end
        iWP_N = 1'b1;
        cmd(8'h00); addr(8'h00); addr(8'h01); cmd(8'h30);
        busy_len(n);
        rd_byte(b, oe);
        tests_run++;
        if (b !== 8'hA0) begin tests_failed++; $display("FAIL wp_keep0: got %h expected a0", b); end
        rd_byte(b, oe);
        tests_run++;
        if (b !== 8'hA1) begin tests_failed++; $display("FAIL wp_keep1: got %h expected a1", b); end
    endtask

    task automatic test_status_in_busy;
        logic [7:0] b;
        logic oe;
        bit ok;
        cmd(8'h00); addr(8'h05); addr(8'h02); cmd(8'h30);
        repeat (3) @(negedge clk);
        cmd(8'h70);
        rd_byte(b, oe);
        tests_run++;
        if (b !== 8'h80) begin tests_failed++; $display("FAIL busy_status: got %h expected 80", b); end
        wait_ready(ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL busy_timeout: got busy expected ready"); end
        rd_byte(b, oe);
        tests_run++;
        if (b !== 8'hC0) begin tests_failed++; $display("FAIL ready_status: got %h expected c0", b); end
        cmd(8'h00);
        rd_byte(b, oe);
        tests_run++;
        if (b !== 8'h16) begin tests_failed++; $display("FAIL resume_col5: got %h expected 16", b); end
        rd_byte(b, oe);
        tests_run++;
        if (b !== 8'h17) begin tests_failed++; $display("FAIL resume_col6: got %h expected 17", b); end
    endtask

    task automatic test_id_and_reset;
        logic [7:0] b;
        logic [7:0] exp [3];
        logic oe;
        int n;
        exp[0] = 8'hEC; exp[1] = 8'hDA; exp[2] = 8'h00;
        cmd(8'h90); addr(8'h00);
        for (int i = 0; i < 3; i++) begin
            rd_byte(b, oe);
            tests_run++;
            if (b !== exp[i]) begin tests_failed++; $display("FAIL id_byte%0d: got %h expected %h", i, b, exp[i]); end
        end
        iWP_N = 1'b0;
        cmd(8'h80); addr(8'h00); addr(8'h03); din(8'h77); cmd(8'h10);
        repeat (5) @(negedge clk);
        iWP_N = 1'b1;
        cmd(8'hFF);
        busy_len(n);
        tests_run++;
        if (n != 32) begin tests_failed++; $display("FAIL rst_busy: got %0d cycles expected 32", n); end
        rd_byte(b, oe);
        tests_run++;
        if (oe !== 1'b0) begin tests_failed++; $display("FAIL rst_oe: got %b expected 0", oe); end
        tests_run++;
        if (b !== 8'hAA) begin tests_failed++; $display("FAIL rst_idle_q: got %h expected aa", b); end
        cmd(8'h70);
        rd_byte(b, oe);
        tests_run++;
        if (b !== 8'hC0) begin tests_failed++; $display("FAIL rst_status: got %h expected c0", b); end
    endtask

    task automatic test_chip_enable;
        logic [7:0] b;
        logic oe;
        @(negedge clk);
        iCE_N = 1'b1;
        rd_byte(b, oe);
        tests_run++;
        if (oe !== 1'b0 || b !== 8'hAA) begin
            tests_failed++;
            $display("FAIL ce_high: got oe=%b q=%h expected oe=0 q=aa", oe, b);
        end
        cmd(8'h80);
        @(negedge clk);
        iCE_N = 1'b0;
        rd_byte(b, oe);
        tests_run++;
        if (b !== 8'hC0) begin tests_failed++; $display("FAIL ce_ignored_cmd: got %h expected c0", b); end
    endtask

    initial begin
        test_reset();
        test_program_read();
        test_column_wrap();
        test_write_protect();
        test_status_in_busy();
        test_id_and_reset();
        test_chip_enable();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

endmodule
